blft_stream: RTL and testbench

//  Streaming 3x3 edge-preserving filter, successor to the address-driven blft core.

---
 rtl/blft_stream.sv | 217 +++++++++++++++++++++
 tb/tb_blft_stream.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/blft_stream.sv
// Streaming 3x3 bypass / Gaussian / bilateral filter over a raster frame.
// Two line buffers plus a 2-column window register; bilateral pixels stall for a serial divide.
module blft_stream #(
    parameter int DW     = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int AW     = 16,
    parameter int RSHIFT = 3,
    parameter int WMAX   = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          finish
);
    localparam int WW   = $clog2(WMAX + 1);
    localparam int NW   = DW + 4 + WW;
    localparam int DENW = 4 + WW;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX + IMG_W + 1);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int QW   = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [CW-1:0] TRIG_C = CW'(IMG_W + 1);
    localparam logic [CW-1:0] LAST_C = CW'(NPIX - 1);
    localparam logic [CW-1:0] NPIX_C = CW'(NPIX);
    localparam logic [CW-1:0] END_C  = CW'(NPIX + IMG_W);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [QW-1:0] D_LAST = QW'(DW - 1);
    localparam logic [DW-1:0] WMAX_D = DW'(WMAX);

    typedef enum logic [2:0] {IDLE, RUN, DIV, FLUSH, DONE} state_t;
    state_t state, nxt;

    logic [1:0]    mode_q;
    logic [CW-1:0] cnt;
    logic [XW-1:0] icol, ccol;
    logic [YW-1:0] crow;
    logic [AW-1:0] caddr, div_addr;
    logic [QW-1:0] dcnt;
    logic [NW-1:0] rem, dsh;
    logic [DW-1:0] quo;
    logic          ge;

    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    logic [2:0][1:0][DW-1:0] win;
    logic [2:0][2:0][DW-1:0] p;

    logic          accept, flushing, step, trig, border, bil;
    logic [DW-1:0] din, pc;
    logic [DW+3:0] gsum;
    logic [NW-1:0] num;
    logic [DENW-1:0] den;
    logic [DW-1:0] diff, dq;
    logic [WW-1:0] wr;
    logic [WW+1:0] wgt;
    int            sh;

    assign accept   = in_valid & in_ready;
    assign flushing = (state == FLUSH);
    assign step     = accept | flushing;
    assign din      = flushing ? '0 : in_data;
    assign trig     = step && (cnt >= TRIG_C);
    assign border   = (crow == '0) || (crow == Y_LAST) || (ccol == '0) || (ccol == X_LAST);
    assign bil      = (mode_q == 2'd2) && !border;
    assign pc       = p[1][1];
    assign ge       = (rem >= dsh);

    // Right-hand window column comes straight from the line buffers and the incoming pixel,
    // so the full neighbourhood is available in the accept cycle.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            p[r][0] = win[r][0];
            p[r][1] = win[r][1];
        end
        p[0][2] = lb1[icol];
        p[1][2] = lb0[icol];
        p[2][2] = din;
    end

    always_comb begin
        gsum = '0;
        num  = '0;
        den  = '0;
        diff = '0;
        dq   = '0;
        wr   = '0;
        wgt  = '0;
        sh   = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sh   = ((r == 1) ? 1 : 0) + ((c == 1) ? 1 : 0);
                diff = (p[r][c] > pc) ? p[r][c] - pc : pc - p[r][c];
                dq   = diff >> RSHIFT;
                wr   = (dq >= WMAX_D) ? '0 : WW'(WMAX_D - dq);
                wgt  = (WW + 2)'(wr) << sh;
                gsum = gsum + ((DW + 4)'(p[r][c]) << sh);
                num  = num + NW'(wgt) * NW'(p[r][c]);
                den  = den + DENW'(wgt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt      = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !finish;
                if (accept) nxt = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (trig && bil)         nxt = DIV;
                    else if (cnt == LAST_C)  nxt = FLUSH;
                end
            end
            DIV:   if (dcnt == D_LAST) nxt = (cnt == NPIX_C) ? FLUSH : RUN;
            FLUSH: if (cnt == END_C) nxt = DONE;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (step) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= p[r][2];
            end
            lb1[icol] <= lb0[icol];
            lb0[icol] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            finish    <= 1'b0;
            mode_q    <= '0;
            cnt       <= '0;
            icol      <= '0;
            ccol      <= '0;
            crow      <= '0;
            caddr     <= '0;
            div_addr  <= '0;
            dcnt      <= '0;
            rem       <= '0;
            dsh       <= '0;
            quo       <= '0;
        end else begin
            out_valid <= 1'b0;
            finish    <= (state == DONE);
            if (state == IDLE && accept) mode_q <= mode;
            if (step) begin
                cnt  <= cnt + CW'(1);
                icol <= (icol == X_LAST) ? '0 : icol + XW'(1);
            end
            if (trig) begin
                caddr <= caddr + AW'(1);
                if (ccol == X_LAST) begin
                    ccol <= '0;
                    crow <= crow + YW'(1);
                end else begin
                    ccol <= ccol + XW'(1);
                end
                if (bil) begin
                    rem      <= num;
                    dsh      <= NW'(den) << (DW - 1);
                    quo      <= '0;
                    dcnt     <= '0;
                    div_addr <= caddr;
                end else begin
                    out_valid <= 1'b1;
                    out_addr  <= caddr;
                    out_data  <= (!border && mode_q == 2'd1) ? gsum[DW+3:4] : pc;
                end
            end
            // One restoring-division bit per cycle; quotient is a weighted mean so it fits DW bits.
            if (state == DIV) begin
                rem  <= ge ? rem - dsh : rem;
                dsh  <= dsh >> 1;
                quo  <= {quo[DW-2:0], ge};
                dcnt <= dcnt + QW'(1);
                if (dcnt == D_LAST) begin
                    out_valid <= 1'b1;
                    out_addr  <= div_addr;
                    out_data  <= {quo[DW-2:0], ge};
                end
            end
            if (state == DONE) begin
                cnt   <= '0;
                icol  <= '0;
                ccol  <= '0;
                crow  <= '0;
                caddr <= '0;
            end
        end
    end
endmodule

// File: tb/tb_blft_stream.sv
// Randomised bench for blft_stream (8x8 frames) checked against a per-pixel arithmetic model.
module tb_blft_stream;
    localparam int DW = 8, W = 8, H = 8, AW = 16, N = W * H;
    localparam int MID_STALLS = ((W - 2) * (H - 2) - 1) * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          finish;

    always #5 clk = ~clk;

    blft_stream #(.DW(DW), .IMG_W(W), .IMG_H(H), .AW(AW), .RSHIFT(3), .WMAX(15)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_addr(out_addr),
        .out_data(out_data), .finish(finish)
    );

    int tests = 0, fails = 0;
    int img [N];
    int got [N];
    int ea_q[$], ed_q[$];
    int fin_seen = 0;
    bit prev_ov = 0;
    int prev_addr = 0;
    int st;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pix(int r, int c);
        return img[r * W + c];
    endfunction

    // Direct evaluation of the filter definition for one output position.
    function automatic int model(int m, int r, int c);
        int pc, s, num, den, ks, wr, d;
        pc = pix(r, c);
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1 || m == 0 || m == 3) return pc;
        s = 0; num = 0; den = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                ks = (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
                s += ks * pix(r + dr, c + dc);
                d = pix(r + dr, c + dc) - pc;
                if (d < 0) d = -d;
                d = d >> 3;
                wr = 15 - (d < 15 ? d : 15);
                num += ks * wr * pix(r + dr, c + dc);
                den += ks * wr;
            end
        if (m == 1) return s / 16;
        return num / den;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            if (ea_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("out_addr", int'(out_addr), ea_q.pop_front());
                check("out_data", int'(out_data), ed_q.pop_front());
                if (out_addr < N) got[out_addr] = out_data;
            end
        end
        if (finish || (prev_ov && prev_addr == N - 1)) begin
            check("finish_timing", int'(finish), int'(prev_ov && prev_addr == N - 1));
            if (finish) fin_seen++;
        end
        prev_ov = out_valid;
        prev_addr = out_addr;
    end

    task automatic drive(input int m, input int gap_pct, input bit toggle, input int limit,
                         output int stalls);
        int acc, budget;
        bit toggled;
        for (int a = 0; a < N; a++) begin
            ea_q.push_back(a);
            ed_q.push_back(model(m, a / W, a % W));
        end
        mode = 2'(m);
        stalls = 0; acc = 0; budget = 0; toggled = 0;
        while (acc < limit) begin
            @(negedge clk);
            budget++;
            if (budget > 20000) begin
                check("drive_timeout", acc, limit);
                break;
            end
            if (toggle && acc >= 1 && !toggled) begin
                mode = 2'($urandom_range(0, 3));
                toggled = 1;
            end
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                continue;
            end
            in_valid = 1'b1;
            in_data  = DW'(img[acc]);
            if (in_ready) acc++;
            else stalls++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_finish();
        int start, cyc;
        start = fin_seen; cyc = 0;
        while (fin_seen == start && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("finish_seen", fin_seen - start, 1);
        check("all_outputs_emitted", ea_q.size(), 0);
    endtask

    task automatic rand_img();
        for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
    endtask

    initial begin
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_addr", int'(out_addr), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_finish", int'(finish), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk) rst = 1'b1;

        // ramp, bypass, held valid
        for (int i = 0; i < N; i++) img[i] = i;
        drive(0, 0, 0, N, st);
        wait_finish();
        check("ramp_stalls", st, 0);
        check("ramp_addr0", got[0], 0);
        check("ramp_addr37", got[37], 37);
        check("ramp_addr63", got[63], 63);

        // impulse, gaussian
        for (int i = 0; i < N; i++) img[i] = 0;
        img[2 * W + 2] = 160;
        drive(1, 0, 0, N, st);
        wait_finish();
        check("imp_22", got[2 * W + 2], 40);
        check("imp_12", got[1 * W + 2], 20);
        check("imp_11", got[1 * W + 1], 10);
        check("imp_33", got[3 * W + 3], 10);
        check("imp_44", got[4 * W + 4], 0);
        check("imp_stalls", st, 0);

        // step edge, gaussian then bilateral
        for (int i = 0; i < N; i++) img[i] = (i % W >= 4) ? 200 : 0;
        drive(1, 0, 0, N, st);
        wait_finish();
        check("step_g_col3", got[3 * W + 3], 50);
        check("step_g_col4", got[3 * W + 4], 150);
        drive(2, 0, 0, N, st);
        wait_finish();
        check("step_b_col3", got[3 * W + 3], 0);
        check("step_b_col4", got[3 * W + 4], 200);
        check("step_b_stalls", st, MID_STALLS);

        // constant, bilateral
        for (int i = 0; i < N; i++) img[i] = 100;
        drive(2, 0, 0, N, st);
        wait_finish();
        check("const_b_stalls", st, MID_STALLS);
        check("const_b_45", got[45], 100);

        // reset mid-frame, then a fresh frame
        rand_img();
        drive(0, 0, 0, 10, st);
        @(negedge clk) rst = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_addr", int'(out_addr), 0);
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        ea_q.delete();
        ed_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rand_img();
        drive(1, 0, 0, N, st);
        wait_finish();

        // random images with input gaps and a mode change after the first accept
        for (int f = 0; f < 4; f++) begin
            rand_img();
            drive(f, 30, 1, N, st);
            wait_finish();
        end
        rand_img();
        drive(2, 0, 0, N, st);
        wait_finish();
        check("rand_b_stalls", st, MID_STALLS);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
